// File: rtl/counter_modn_disp.sv
// counter_modn_disp: prescaled up/down mod-N counter with wrap pulse and active-low 7-segment decode. Ports: CLK, rst_n (sync, active-low), iEn/iUp/iLoad/iData in; oQ count, oCarry wrap pulse, oTick prescaler terminal count, oDisplay {g..a}.
module counter_modn_disp #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10,
  parameter int DIV     = 50000000
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             iEn,
  input  logic             iUp,
  input  logic             iLoad,
  input  logic [WIDTH-1:0] iData,
  output logic [WIDTH-1:0] oQ,
  output logic             oCarry,
  output logic             oTick,
  output logic [6:0]       oDisplay
);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  if (WIDTH < 4 || MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH) || DIV < 1) begin : g_bad
    $error("counter_modn_disp: illegal WIDTH/MODULUS/DIV");
  end
  logic [PW-1:0]    pre;
  logic [WIDTH-1:0] q_nx;
  logic             wrap, step;
  assign oTick = pre == PW'(DIV - 1);
  assign oDisplay = SEG[oQ[3:0]];
  always_comb begin
    step = oTick && iEn;
    wrap = iUp ? oQ == TOP : oQ == '0;
    q_nx = wrap ? (iUp ? '0 : TOP) : (iUp ? oQ + 1'b1 : oQ - 1'b1);
  end
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      pre    <= '0;
      oQ     <= '0;
      oCarry <= 1'b0;
    end else if (iLoad) begin
      pre    <= '0;
      oQ     <= ({1'b0, iData} < (WIDTH + 1)'(MODULUS)) ? iData : '0;
      oCarry <= 1'b0;
    end else begin
      pre    <= oTick ? '0 : pre + 1'b1;
      oQ     <= step ? q_nx : oQ;
      oCarry <= step && wrap;
    end
  end
endmodule

// File: tb/tb_counter_modn_disp.sv
// tb_counter_modn_disp: randomized and directed checks of counter_modn_disp against an arithmetic reference model.
module tb_counter_modn_disp;
  localparam int M = 10, DV = 4;
  logic clk = 1'b0;
  logic rst_n, en, up, load, en8, up8, load8;
  logic [3:0] data, q;
  logic [7:0] data8, q8;
  logic carry, tick, c8, t8;
  logic [6:0] disp, d8;
  logic [6:0] SEG7 [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int ph, mq, m8, nv, ne;
  bit mc, c8m;
  always #5 clk = ~clk;
  counter_modn_disp #(.WIDTH(4), .MODULUS(M), .DIV(DV)) dut_a (
    .CLK(clk), .rst_n(rst_n), .iEn(en), .iUp(up), .iLoad(load), .iData(data),
    .oQ(q), .oCarry(carry), .oTick(tick), .oDisplay(disp));
  counter_modn_disp #(.WIDTH(8), .MODULUS(256), .DIV(1)) dut_b (
    .CLK(clk), .rst_n(rst_n), .iEn(en8), .iUp(up8), .iLoad(load8), .iData(data8),
    .oQ(q8), .oCarry(c8), .oTick(t8), .oDisplay(d8));
  function automatic logic [12:0] exp_a();
    return {4'(mq), mc, 1'(ph % DV == DV - 1), SEG7[mq]};
  endfunction
  function automatic logic [16:0] exp_b();
    return {8'(m8), c8m, 1'b1, SEG7[m8 % 16]};
  endfunction
  task automatic cyc();
    int raw;
    if (!rst_n) begin
      ph = 0; mq = 0; mc = 0; m8 = 0; c8m = 0;
    end else begin
      if (load) begin
        ph = 0; mq = int'(data) < M ? int'(data) : 0; mc = 0;
      end else begin
        if (ph % DV == DV - 1 && en) begin
          raw = mq + (up ? 1 : -1);
          mc = raw < 0 || raw >= M;
          mq = (raw + M) % M;
        end else mc = 0;
        ph++;
      end
      if (load8) begin
        m8 = int'(data8); c8m = 0;
      end else if (en8) begin
        raw = m8 + (up8 ? 1 : -1);
        c8m = raw < 0 || raw > 255;
        m8 = (raw + 256) % 256;
      end else c8m = 0;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_n = 0; en = 1; up = 1; load = 1; data = 4'd7; en8 = 1; load8 = 1; data8 = 8'h55;
    repeat (2) begin
      cyc();
      nv++;
      if ({q, carry, tick, disp, q8, c8} !== {4'd0, 1'b0, 1'b0, 7'h40, 8'd0, 1'b0}) begin
        ne++; $display("FAIL reset: got q=%0d c=%b t=%b d=%h q8=%h want 0/0/0/40/00", q, carry, tick, disp, q8);
      end
    end
    load = 0; en = 0; en8 = 0; load8 = 0;
  endtask
  task automatic test_count_up();
    int ticks = 0, carries = 0;
    rst_n = 1; en = 1; up = 1;
    for (int i = 1; i <= 44; i++) begin
      cyc();
      ticks += int'(tick); carries += int'(carry);
      nv++;
      if ({q, carry, tick, disp} !== exp_a()) begin
        ne++; $display("FAIL count_up[%0d]: got %h want %h", i, {q, carry, tick, disp}, exp_a());
      end
    end
    nv++;
    if (ticks !== 11 || carries !== 1) begin
      ne++; $display("FAIL count_up_pulses: got ticks=%0d carries=%0d want 11/1", ticks, carries);
    end
  endtask
  task automatic test_down();
    load = 1; data = 4'd0; cyc(); load = 0; up = 0; en = 1;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      nv++;
      if ({q, carry, tick, disp} !== exp_a()) begin
        ne++; $display("FAIL down[%0d]: got %h want %h", i, {q, carry, tick, disp}, exp_a());
      end
      if (i == 4 || i == 5 || i == 8 || i == 12) begin
        nv++;
        if ({q, carry} !== (i == 4 ? {4'd9, 1'b1} : i == 5 ? {4'd9, 1'b0} : i == 8 ? {4'd8, 1'b0} : {4'd7, 1'b0})) begin
          ne++; $display("FAIL down_seq[%0d]: got q=%0d c=%b", i, q, carry);
        end
      end
    end
  endtask
  task automatic test_load();
    up = 1; en = 1;
    cyc(); cyc();
    load = 1; data = 4'd7; cyc(); load = 0;
    nv++;
    if ({q, carry, tick} !== {4'd7, 1'b0, 1'b0}) begin
      ne++; $display("FAIL load7: got q=%0d c=%b t=%b want 7/0/0", q, carry, tick);
    end
    for (int i = 1; i <= 4; i++) begin
      cyc();
      nv++;
      if ({q, carry, tick, disp} !== exp_a() || (i == 3 && {q, tick} !== {4'd7, 1'b1}) || (i == 4 && q !== 4'd8)) begin
        ne++; $display("FAIL load_step[%0d]: got %h want %h", i, {q, carry, tick, disp}, exp_a());
      end
    end
    load = 1; data = 4'd12; cyc(); load = 0;
    nv++;
    if ({q, carry, disp} !== {4'd0, 1'b0, 7'h40}) begin
      ne++; $display("FAIL load12: got q=%0d c=%b d=%h want 0/0/40", q, carry, disp);
    end
  endtask
  task automatic test_enable();
    int ticks = 0;
    en = 0; up = 1;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      ticks += int'(tick);
      nv++;
      if ({q, carry, tick, disp} !== exp_a() || q !== 4'd0) begin
        ne++; $display("FAIL enable_hold[%0d]: got %h want %h", i, {q, carry, tick, disp}, exp_a());
      end
    end
    en = 1;
    repeat (4) cyc();
    nv++;
    if (ticks !== 2 || q !== 4'd1 || {q, carry, tick, disp} !== exp_a()) begin
      ne++; $display("FAIL enable_resume: got ticks=%0d q=%0d want 2/1", ticks, q);
    end
  endtask
  task automatic test_mid_reset();
    load = 1; data = 4'd5; cyc(); load = 0; en = 1; up = 1;
    repeat (3) cyc();
    nv++;
    if ({q, tick} !== {4'd5, 1'b1}) begin
      ne++; $display("FAIL mid_reset_pre: got q=%0d t=%b want 5/1", q, tick);
    end
    rst_n = 0; cyc(); rst_n = 1;
    nv++;
    if ({q, carry, tick} !== {4'd0, 1'b0, 1'b0}) begin
      ne++; $display("FAIL mid_reset: got q=%0d c=%b t=%b want 0/0/0", q, carry, tick);
    end
    for (int i = 1; i <= 5; i++) begin
      cyc();
      nv++;
      if ({q, carry, tick, disp} !== exp_a() || (i == 3 && {q, tick} !== {4'd0, 1'b1}) || (i == 4 && q !== 4'd1)) begin
        ne++; $display("FAIL mid_reset_after[%0d]: got %h want %h", i, {q, carry, tick, disp}, exp_a());
      end
    end
  endtask
  task automatic test_wide();
    en = 0; load8 = 1; data8 = 8'h3A; cyc(); load8 = 0;
    nv++;
    if ({q8, d8, t8} !== {8'h3A, 7'h08, 1'b1}) begin
      ne++; $display("FAIL wide_3a: got q8=%h d8=%h t8=%b want 3a/08/1", q8, d8, t8);
    end
    load8 = 1; data8 = 8'hFD; cyc(); load8 = 0; en8 = 1; up8 = 1;
    for (int i = 1; i <= 8; i++) begin
      if (i == 6) up8 = 0;
      cyc();
      nv++;
      if ({q8, c8, t8, d8} !== exp_b() || (i == 3 && {q8, c8} !== {8'h00, 1'b1}) || (i == 8 && {q8, c8} !== {8'hFF, 1'b1})) begin
        ne++; $display("FAIL wide[%0d]: got %h want %h", i, {q8, c8, t8, d8}, exp_b());
      end
    end
    en8 = 0;
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n = $urandom_range(0, 49) != 0;
      en = $urandom_range(0, 3) != 0; up = 1'($urandom); load = $urandom_range(0, 15) == 0; data = 4'($urandom);
      en8 = 1'($urandom); up8 = 1'($urandom); load8 = $urandom_range(0, 19) == 0; data8 = 8'($urandom);
      cyc();
      nv++;
      if ({q, carry, tick, disp} !== exp_a() || {q8, c8, t8, d8} !== exp_b()) begin
        ne++; $display("FAIL random[%0d]: got a=%h b=%h want a=%h b=%h", i, {q, carry, tick, disp}, {q8, c8, t8, d8}, exp_a(), exp_b());
      end
    end
    rst_n = 1;
  endtask
  initial begin
    nv = 0; ne = 0; ph = 0; mq = 0; mc = 0; m8 = 0; c8m = 0;
    rst_n = 0; en = 0; up = 0; load = 0; data = '0; en8 = 0; up8 = 0; load8 = 0; data8 = '0;
    test_reset();
    test_count_up();
    test_down();
    test_load();
    test_enable();
    test_mid_reset();
    test_wide();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nv, ne);
    $finish;
  end
endmodule
